// File: rtl/planificador_nonces_pkg.sv
// Shared types and helpers for the nonce scheduler.
// State encoding, data widths and the hash-vs-target compare.
package planificador_pkg;

    localparam int ANCHO_NONCE  = 32;
    localparam int ANCHO_HASH   = 24;
    localparam int ANCHO_TARGET = 8;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        DESPACHO = 2'd1,
        DRENAJE  = 2'd2,
        HECHO    = 2'd3
    } estado_e;

    function automatic logic es_acierto(
        input logic [ANCHO_HASH-1:0]   hash,
        input logic [ANCHO_TARGET-1:0] tgt
    );
        return hash[ANCHO_HASH-1 -: ANCHO_TARGET] < tgt;
    endfunction

endpackage

// File: rtl/planificador_nonces_if.sv
// Scheduler <-> hash core array bundle.
// master = scheduler side, slave = core array side.
interface planificador_nonces_if
    import planificador_pkg::*;
#(
    parameter int NUM_NUCLEOS = 4
);
    logic [NUM_NUCLEOS-1:0]             nucleo_listo;
    logic [NUM_NUCLEOS-1:0]             nucleo_carga;
    logic [ANCHO_NONCE-1:0]             nonce_emit;
    logic [NUM_NUCLEOS-1:0]             res_valido;
    logic [NUM_NUCLEOS*ANCHO_HASH-1:0]  res_hash;
    logic [NUM_NUCLEOS*ANCHO_NONCE-1:0] res_nonce;

    modport master (
        input  nucleo_listo,
        input  res_valido,
        input  res_hash,
        input  res_nonce,
        output nucleo_carga,
        output nonce_emit
    );

    modport slave (
        output nucleo_listo,
        output res_valido,
        output res_hash,
        output res_nonce,
        input  nucleo_carga,
        input  nonce_emit
    );
endinterface

// File: rtl/planificador_nonces_arbitro_rr.sv
// Round-robin arbiter: search starts at the core after the last grant.
// The pointer only moves when a grant is actually issued.
module arbitro_rr #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          hallado;
    int            idx;

    always_comb begin
        gnt_o   = '0;
        ptr_d   = ptr_q;
        hallado = 1'b0;
        idx     = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr_q) + off) % N;
            if (en_i && !hallado && req_i[idx]) begin
                hallado    = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_d      = PW'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/planificador_nonces.sv
// Nonce scheduler: round-robin issue to hash cores, first-hit latch, drain.
// PLANIFICADOR_INTENTOS_EN adds the saturating `intentos` result counter.
module planificador_nonces
    import planificador_pkg::*;
#(
    parameter int NUM_NUCLEOS = 4,
    parameter int MAX_PEND    = 15
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    inicio,
    input  logic [ANCHO_TARGET-1:0] target,
    input  logic [1:0]              num_entradas,
    input  logic [ANCHO_NONCE-1:0]  nonce_base,
    planificador_nonces_if.master   nuc,
    output logic                    fin,
    output logic                    encontrado,
    output logic [ANCHO_NONCE-1:0]  nonce_valido_out,
    output logic [ANCHO_HASH-1:0]   bounty_out
`ifdef PLANIFICADOR_INTENTOS_EN
    ,
    output logic [31:0]             intentos
`endif
);
    localparam int PEND_W = $clog2(MAX_PEND + 1);

    estado_e                 estado_q, estado_d;
    logic [ANCHO_NONCE-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0]       pend_q, pend_d;
    logic [NUM_NUCLEOS-1:0]  mask_q, mask_d;
    logic [ANCHO_TARGET-1:0] tgt_q, tgt_d;
    logic                    fin_q, fin_d;
    logic                    enc_q, enc_d;
    logic [ANCHO_NONCE-1:0]  nout_q, nout_d;
    logic [ANCHO_HASH-1:0]   bty_q, bty_d;

    logic                    emite_en, emite;
    logic [NUM_NUCLEOS-1:0]  gnt;
    logic                    hit;
    logic [ANCHO_NONCE-1:0]  hit_nonce;
    logic [ANCHO_HASH-1:0]   hit_hash;
    int                      pop;
    int                      suma;

    assign emite_en = (estado_q == DESPACHO) &&
                      (pend_q < PEND_W'(MAX_PEND));

    arbitro_rr #(.N(NUM_NUCLEOS)) u_arb (
        .clk   (clk),
        .rst_n (reset_L),
        .req_i (nuc.nucleo_listo & mask_q),
        .en_i  (emite_en),
        .gnt_o (gnt)
    );

    assign emite            = |gnt;
    assign nuc.nucleo_carga = gnt;
    assign nuc.nonce_emit   = cnt_q;

    // Walk downwards so the lowest-index hit overrides the others.
    always_comb begin
        pop       = 0;
        hit       = 1'b0;
        hit_nonce = '0;
        hit_hash  = '0;
        for (int i = NUM_NUCLEOS - 1; i >= 0; i--) begin
            pop = pop + int'(nuc.res_valido[i]);
            if (nuc.res_valido[i] &&
                es_acierto(nuc.res_hash[i*ANCHO_HASH +: ANCHO_HASH], tgt_q)) begin
                hit       = 1'b1;
                hit_nonce = nuc.res_nonce[i*ANCHO_NONCE +: ANCHO_NONCE];
                hit_hash  = nuc.res_hash[i*ANCHO_HASH +: ANCHO_HASH];
            end
        end
    end

    always_comb begin
        suma   = int'(pend_q) + int'(emite);
        pend_d = pend_q;
        if (estado_q != REPOSO) begin
            suma   = (suma > pop) ? suma - pop : 0;
            pend_d = PEND_W'(suma);
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        tgt_d    = tgt_q;
        fin_d    = fin_q;
        enc_d    = enc_q;
        nout_d   = nout_q;
        bty_d    = bty_q;
        unique case (estado_q)
            REPOSO, HECHO: begin
                if (inicio) begin
                    cnt_d  = nonce_base;
                    tgt_d  = target;
                    fin_d  = 1'b0;
                    enc_d  = 1'b0;
                    nout_d = '0;
                    bty_d  = '0;
                    for (int i = 0; i < NUM_NUCLEOS; i++) begin
                        mask_d[i] = (i <= int'(num_entradas));
                    end
                    estado_d = DESPACHO;
                end
            end
            DESPACHO: begin
                if (emite) begin
                    if (cnt_q == '1) begin
                        estado_d = DRENAJE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (hit) begin
                    enc_d    = 1'b1;
                    nout_d   = hit_nonce;
                    bty_d    = hit_hash;
                    estado_d = DRENAJE;
                end
            end
            DRENAJE: begin
                if (pend_d == '0) begin
                    fin_d    = 1'b1;
                    estado_d = HECHO;
                end
            end
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            estado_q <= REPOSO;
            cnt_q    <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            tgt_q    <= '0;
            fin_q    <= 1'b0;
            enc_q    <= 1'b0;
            nout_q   <= '0;
            bty_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            tgt_q    <= tgt_d;
            fin_q    <= fin_d;
            enc_q    <= enc_d;
            nout_q   <= nout_d;
            bty_q    <= bty_d;
        end
    end

    assign fin              = fin_q;
    assign encontrado       = enc_q;
    assign nonce_valido_out = nout_q;
    assign bounty_out       = bty_q;

`ifdef PLANIFICADOR_INTENTOS_EN
    logic [31:0] int_q, int_d;
    logic [32:0] int_sum;

    always_comb begin
        int_sum = {1'b0, int_q} + 33'(pop);
        int_d   = int_q;
        if ((estado_q == REPOSO || estado_q == HECHO) && inicio) begin
            int_d = '0;
        end else if (estado_q == DESPACHO || estado_q == DRENAJE) begin
            int_d = int_sum[32] ? '1 : int_sum[31:0];
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            int_q <= '0;
        end else begin
            int_q <= int_d;
        end
    end

    assign intentos = int_q;
`endif

endmodule

// File: tb/tb_planificador_nonces.sv
// Scoreboard bench for planificador_nonces (issue and fin queues).
// Define PLANIFICADOR_INTENTOS_EN to also check the intentos counter.
module tb_planificador_nonces;
    import planificador_pkg::*;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        inicio;
    logic [7:0]  target;
    logic [1:0]  num_entradas;
    logic [31:0] nonce_base;
    logic        fin, encontrado;
    logic [31:0] nonce_valido_out;
    logic [23:0] bounty_out;
`ifdef PLANIFICADOR_INTENTOS_EN
    logic [31:0] intentos;
`endif

    planificador_nonces_if #(.NUM_NUCLEOS(4)) bus ();

    planificador_nonces #(.NUM_NUCLEOS(4), .MAX_PEND(15)) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .inicio           (inicio),
        .target           (target),
        .num_entradas     (num_entradas),
        .nonce_base       (nonce_base),
        .nuc              (bus),
        .fin              (fin),
        .encontrado       (encontrado),
        .nonce_valido_out (nonce_valido_out),
        .bounty_out       (bounty_out)
`ifdef PLANIFICADOR_INTENTOS_EN
        ,
        .intentos         (intentos)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          core;
        logic [31:0] nonce;
    } issue_t;

    typedef struct {
        logic        enc;
        logic [31:0] nonce;
        logic [23:0] bounty;
        logic [31:0] cuenta;
    } fin_t;

    issue_t exp_iss[$];
    fin_t   exp_fin[$];
    int     n_chk  = 0;
    int     n_fail = 0;
    logic   fin_prev = 1'b0;

    task automatic check(input string nombre, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nombre, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arranque(input logic [31:0] base, input logic [1:0] ne,
                            input logic [7:0] tgt);
        nonce_base   = base;
        num_entradas = ne;
        target       = tgt;
        inicio       = 1'b1;
        tick();
        inicio = 1'b0;
    endtask

    task automatic pon_res(input int core, input logic [23:0] h,
                           input logic [31:0] n);
        bus.res_valido[core]          = 1'b1;
        bus.res_hash[core*24 +: 24]   = h;
        bus.res_nonce[core*32 +: 32]  = n;
    endtask

    task automatic limpia_res();
        bus.res_valido = '0;
        bus.res_hash   = '0;
        bus.res_nonce  = '0;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
        tick();
    endtask

    task automatic push_iss(input int core, input logic [31:0] n);
        issue_t e;
        e.core  = core;
        e.nonce = n;
        exp_iss.push_back(e);
    endtask

    task automatic push_fin(input logic enc, input logic [31:0] n,
                            input logic [23:0] b, input logic [31:0] c);
        fin_t f;
        f.enc    = enc;
        f.nonce  = n;
        f.bounty = b;
        f.cuenta = c;
        exp_fin.push_back(f);
    endtask

    // Monitor: compare every issue and every rising fin against the queues.
    always @(negedge clk) begin
        issue_t e;
        fin_t   f;
        logic [3:0] uno;
        if (bus.nucleo_carga !== 4'b0000) begin
            if (exp_iss.size() == 0) begin
                check("unexpected_issue", 64'(bus.nucleo_carga), 64'd0);
            end else begin
                e   = exp_iss.pop_front();
                uno = 4'b0001 << e.core;
                check("issue_core", 64'(bus.nucleo_carga), 64'(uno));
                check("issue_nonce", 64'(bus.nonce_emit), 64'(e.nonce));
            end
        end
        if (fin === 1'b1 && fin_prev !== 1'b1) begin
            if (exp_fin.size() == 0) begin
                check("unexpected_fin", 64'(fin), 64'd0);
            end else begin
                f = exp_fin.pop_front();
                check("fin_encontrado", 64'(encontrado), 64'(f.enc));
                check("fin_nonce", 64'(nonce_valido_out), 64'(f.nonce));
                check("fin_bounty", 64'(bounty_out), 64'(f.bounty));
`ifdef PLANIFICADOR_INTENTOS_EN
                check("fin_intentos", 64'(intentos), 64'(f.cuenta));
`endif
            end
        end
        fin_prev = fin;
    end

    initial begin
        reset_L          = 1'b0;
        inicio           = 1'b0;
        target           = '0;
        num_entradas     = '0;
        nonce_base       = '0;
        bus.nucleo_listo = '0;
        limpia_res();

        @(negedge clk);
        check("rst_carga", 64'(bus.nucleo_carga), 64'd0);
        check("rst_emit", 64'(bus.nonce_emit), 64'd0);
        check("rst_fin", 64'(fin), 64'd0);
        check("rst_nonce", 64'(nonce_valido_out), 64'd0);
        tick();
        reset_L = 1'b1;
        tick();

        // Round-robin over all four cores.
        arranque(32'd100, 2'd3, 8'h00);
        for (int i = 0; i < 5; i++) push_iss(i % 4, 32'(100 + i));
        bus.nucleo_listo = 4'b1111;
        repeat (5) tick();
        bus.nucleo_listo = 4'b0000;
        pon_res(0, 24'hFF0000, 32'd100);
        pon_res(1, 24'hFF0000, 32'd101);
        tick();
        limpia_res();

        // Asynchronous reset mid-DESPACHO with pend=3.
        @(posedge clk);
        #1 bus.nucleo_listo = 4'b1111;
        #1 reset_L = 1'b0;
        #1;
        check("arst_carga", 64'(bus.nucleo_carga), 64'd0);
        check("arst_emit", 64'(bus.nonce_emit), 64'd0);
        check("arst_fin", 64'(fin), 64'd0);
        check("arst_enc", 64'(encontrado), 64'd0);
        check("arst_bounty", 64'(bounty_out), 64'd0);
`ifdef PLANIFICADOR_INTENTOS_EN
        check("arst_intentos", 64'(intentos), 64'd0);
`endif
        @(posedge clk);
        #1 reset_L = 1'b1;
        repeat (3) tick();
        bus.nucleo_listo = 4'b0000;

        // Mask to cores 0/1 and backpressure at 15 outstanding.
        arranque(32'd1000, 2'd1, 8'h00);
        for (int i = 0; i < 15; i++) push_iss(i % 2, 32'(1000 + i));
        push_iss(1, 32'd1015);
        bus.nucleo_listo = 4'b1111;
        repeat (18) tick();
        pon_res(0, 24'hFF0000, 32'd1000);
        tick();
        limpia_res();
        repeat (2) tick();
        bus.nucleo_listo = 4'b0000;
        do_reset();

        // Two simultaneous hits: lowest core wins; later hits ignored.
        arranque(32'd248, 2'd3, 8'h10);
        for (int i = 0; i < 4; i++) push_iss(i, 32'(248 + i));
        bus.nucleo_listo = 4'b1111;
        repeat (4) tick();
        bus.nucleo_listo = 4'b0000;
        push_fin(1'b1, 32'd248, 24'h0E0000, 32'd4);
        pon_res(2, 24'h0FABCD, 32'd250);
        pon_res(0, 24'h0E0000, 32'd248);
        tick();
        limpia_res();
        check("hit_enc_latched", 64'(encontrado), 64'd1);
        pon_res(1, 24'h050000, 32'd249);
        pon_res(3, 24'h050000, 32'd251);
        nonce_base = 32'd999;
        inicio     = 1'b1;
        @(negedge clk);
        check("hit_fin_before", 64'(fin), 64'd0);
        tick();
        inicio = 1'b0;
        limpia_res();
        check("hit_fin_after", 64'(fin), 64'd1);
        check("hit_nonce_held", 64'(nonce_valido_out), 64'd248);

        // Restart from HECHO into an exhaustion run.
        arranque(32'hFFFF_FFFD, 2'd0, 8'h00);
        check("restart_fin_drop", 64'(fin), 64'd0);
        check("restart_enc_clr", 64'(encontrado), 64'd0);
        push_iss(0, 32'hFFFF_FFFD);
        push_iss(0, 32'hFFFF_FFFE);
        push_iss(0, 32'hFFFF_FFFF);
        push_fin(1'b0, 32'd0, 24'd0, 32'd3);
        bus.nucleo_listo = 4'b0001;
        repeat (5) tick();
        bus.nucleo_listo = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            pon_res(0, 24'h000000, 32'(32'hFFFF_FFFD + i));
            tick();
            limpia_res();
        end
        check("exh_fin", 64'(fin), 64'd1);
        check("exh_enc", 64'(encontrado), 64'd0);
        repeat (2) tick();

        check("issue_queue_empty", 64'(exp_iss.size()), 64'd0);
        check("fin_queue_empty", 64'(exp_fin.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
